// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: accepts one fetch PC at a time and returns
// the stored instruction (or a fault) after LAT cycles over valid/ready.
module ysyx_23060096_imem_resp #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(LAT + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   inst_d;
  logic          err_d;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   req_off_c;
  logic [31:0]   wr_off_c;
  logic          req_hit_c;
  logic          wr_hit_c;
  logic          req_err_c;
  logic [AW-1:0] req_idx_c;
  logic [AW-1:0] wr_idx_c;

  // Address decode for the fetch and preload ports (byte offset from BASE).
  always_comb begin
    req_off_c = req_addr - BASE;
    wr_off_c  = wr_addr - BASE;
    req_hit_c = (req_addr >= BASE) && ({1'b0, req_off_c} < SPAN);
    wr_hit_c  = (wr_addr >= BASE) && ({1'b0, wr_off_c} < SPAN);
    req_err_c = (req_addr[1:0] != 2'b00) || !req_hit_c;
    req_idx_c = req_off_c[AW+1:2];
    wr_idx_c  = wr_off_c[AW+1:2];
  end

  // Preload write port; low address bits ignored, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (rstn && wr_en && wr_hit_c) begin
      mem[wr_idx_c] <= wr_data;
    end
  end

  // Next-state and response-capture logic; read data is taken pre-write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = rsp_inst;
    err_d   = rsp_err;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          inst_d = req_err_c ? 32'h0 : mem[req_idx_c];
          err_d  = req_err_c;
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LAT - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_inst  <= 32'h0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_inst  <= inst_d;
      rsp_err   <= err_d;
      rsp_valid <= (state_d == RESP);
      req_ready <= (state_d == IDLE);
    end
  end

endmodule
